// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the memory port arbiter.
package mem_port_arbiter_pkg;

    localparam int ADDR_W_DEF       = 16;
    localparam int MEM_DW_DEF       = 40;
    localparam int NUM_BEATS_DEF    = 8;
    localparam int STARVE_LIMIT_DEF = 3;
    localparam int STARVE_W         = 2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RECV = 2'd2
    } arb_state_t;

    typedef enum logic {
        OWN_DMD = 1'b0,
        OWN_PF  = 1'b1
    } owner_t;

    // Counter width able to index n beats (at least one bit).
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle of requester, memory and response signals around the arbiter.
// slave = arbiter side, master = requesters/memory/environment side.
interface mem_port_arbiter_if
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH     = ADDR_W_DEF,
    parameter int MEM_DATA_WIDTH = MEM_DW_DEF
);
    logic                      i_halt;
    logic [ADDR_WIDTH-1:0]     i_dmd_addr;
    logic                      i_dmd_valid;
    logic                      o_dmd_ready;
    logic [ADDR_WIDTH-1:0]     i_pf_addr;
    logic                      i_pf_valid;
    logic                      o_pf_ready;
    logic [ADDR_WIDTH-1:0]     o_mem_req_addr;
    logic                      o_mem_req_valid;
    logic                      i_mem_req_ready;
    logic [MEM_DATA_WIDTH-1:0] i_mem_data;
    logic                      i_mem_data_valid;
    logic                      o_mem_ready;
    logic [MEM_DATA_WIDTH-1:0] o_rsp_data;
    logic                      o_dmd_rsp_valid;
    logic                      o_pf_rsp_valid;
    logic                      o_rsp_last;
    logic                      o_busy;
    logic                      o_stray_beat;

    modport slave (
        input  i_halt, i_dmd_addr, i_dmd_valid, i_pf_addr, i_pf_valid,
               i_mem_req_ready, i_mem_data, i_mem_data_valid,
        output o_dmd_ready, o_pf_ready, o_mem_req_addr, o_mem_req_valid,
               o_mem_ready, o_rsp_data, o_dmd_rsp_valid, o_pf_rsp_valid,
               o_rsp_last, o_busy, o_stray_beat
    );

    modport master (
        output i_halt, i_dmd_addr, i_dmd_valid, i_pf_addr, i_pf_valid,
               i_mem_req_ready, i_mem_data, i_mem_data_valid,
        input  o_dmd_ready, o_pf_ready, o_mem_req_addr, o_mem_req_valid,
               o_mem_ready, o_rsp_data, o_dmd_rsp_valid, o_pf_rsp_valid,
               o_rsp_last, o_busy, o_stray_beat
    );
endinterface

// File: rtl/mem_port_arb_pick.sv
// Demand-over-prefetch priority with a starvation escape for prefetch.
module mem_port_arb_pick
    import mem_port_arbiter_pkg::*;
#(
    parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
    input  logic                dmd_valid_i,
    input  logic                pf_valid_i,
    input  logic [STARVE_W-1:0] starve_cnt_i,
    output owner_t              winner_o
);
    logic starved;

    // Prefetch only wins alone, or when demand has won too often in a row.
    assign starved  = (starve_cnt_i == STARVE_W'(STARVE_LIMIT));
    assign winner_o = (pf_valid_i && (!dmd_valid_i || starved)) ? OWN_PF : OWN_DMD;
endmodule

// File: rtl/mem_port_arbiter.sv
// Two-requester block-fetch arbiter: grants demand or prefetch, issues one
// memory request, then steers NUM_BEATS returning beats to the owner.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH     = ADDR_W_DEF,
    parameter int MEM_DATA_WIDTH = MEM_DW_DEF,
    parameter int NUM_BEATS      = NUM_BEATS_DEF,
    parameter int STARVE_LIMIT   = STARVE_LIMIT_DEF
) (
    input  logic            clk,
    input  logic            arst_n,
    mem_port_arbiter_if.slave bus
);
    localparam int BCNT_W = cnt_width(NUM_BEATS);

    arb_state_t            state_q;
    logic [BCNT_W-1:0]     beat_q;
    logic [STARVE_W-1:0]   starve_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    owner_t                owner_q;

    owner_t                    win;
    logic                      run, in_idle, in_req, in_recv;
    logic                      dmd_grant, pf_grant, any_grant;
    logic                      beat, last_beat;
    logic [MEM_DATA_WIDTH-1:0] rsp_data;

    mem_port_arb_pick #(.STARVE_LIMIT(STARVE_LIMIT)) u_pick (
        .dmd_valid_i  (bus.i_dmd_valid),
        .pf_valid_i   (bus.i_pf_valid),
        .starve_cnt_i (starve_q),
        .winner_o     (win)
    );

    // Anything that moves state or pulses an output needs reset released and no halt.
    assign run     = arst_n & ~bus.i_halt;
    assign in_idle = (state_q == ST_IDLE);
    assign in_req  = (state_q == ST_REQ);
    assign in_recv = (state_q == ST_RECV);

    assign any_grant = run & in_idle & (bus.i_dmd_valid | bus.i_pf_valid);
    assign dmd_grant = any_grant & (win == OWN_DMD);
    assign pf_grant  = any_grant & (win == OWN_PF);

    assign beat      = run & in_recv & bus.i_mem_data_valid;
    assign last_beat = beat & (beat_q == BCNT_W'(NUM_BEATS - 1));
    assign rsp_data  = beat ? bus.i_mem_data : '0;

    assign bus.o_dmd_ready     = dmd_grant;
    assign bus.o_pf_ready      = pf_grant;
    // Request stays up through halt so the memory sees a stable request.
    assign bus.o_mem_req_valid = arst_n & in_req;
    assign bus.o_mem_req_addr  = (arst_n & in_req) ? addr_q : '0;
    assign bus.o_mem_ready     = run & in_recv;
    assign bus.o_rsp_data      = rsp_data;
    assign bus.o_dmd_rsp_valid = beat & (owner_q == OWN_DMD);
    assign bus.o_pf_rsp_valid  = beat & (owner_q == OWN_PF);
    assign bus.o_rsp_last      = last_beat;
    assign bus.o_busy          = arst_n & ~in_idle;
    // Beats arriving while no block is being received are discarded and flagged.
    assign bus.o_stray_beat    = run & ~in_recv & bus.i_mem_data_valid;

    // Transaction FSM with latched address/owner, beat and starvation counters.
    always_ff @(posedge clk) begin
        if (!arst_n) begin
            state_q  <= ST_IDLE;
            beat_q   <= '0;
            starve_q <= '0;
            addr_q   <= '0;
            owner_q  <= OWN_DMD;
        end else if (!bus.i_halt) begin
            case (state_q)
                ST_IDLE: begin
                    if (any_grant) begin
                        addr_q  <= (win == OWN_PF) ? bus.i_pf_addr : bus.i_dmd_addr;
                        owner_q <= win;
                        state_q <= ST_REQ;
                        if (pf_grant)
                            starve_q <= '0;
                        else if (bus.i_pf_valid && (starve_q != '1))
                            starve_q <= starve_q + STARVE_W'(1);
                    end
                end
                ST_REQ: begin
                    if (bus.i_mem_req_ready) begin
                        state_q <= ST_RECV;
                        beat_q  <= '0;
                    end
                end
                ST_RECV: begin
                    if (beat) begin
                        beat_q <= beat_q + BCNT_W'(1);
                        if (last_beat)
                            state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized bench for mem_port_arbiter: a transaction-level model predicts
// grants and returned beats into queues; a negedge monitor checks the DUT.
module tb_mem_port_arbiter;
    localparam int AW  = 16;
    localparam int MDW = 40;
    localparam int NB  = 8;
    localparam int SL  = 3;

    localparam int PH_IDLE = 0;
    localparam int PH_REQ  = 1;
    localparam int PH_RECV = 2;

    typedef struct {
        int cyc;
        bit pf;
    } grant_t;

    typedef struct {
        int           cyc;
        bit           pf;
        logic [MDW-1:0] data;
        bit           last;
    } rsp_t;

    logic clk;
    logic arst_n;
    int   cyc;
    int   checks;
    int   errors;
    int   n_grants;

    mem_port_arbiter_if #(.ADDR_WIDTH(AW), .MEM_DATA_WIDTH(MDW)) bus ();

    mem_port_arbiter #(
        .ADDR_WIDTH(AW), .MEM_DATA_WIDTH(MDW), .NUM_BEATS(NB), .STARVE_LIMIT(SL)
    ) dut (
        .clk    (clk),
        .arst_n (arst_n),
        .bus    (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Reference model state: block phase, owner/address of the block,
    // beats delivered so far, demand wins since the last prefetch grant.
    int            m_phase;
    bit            m_pf;
    logic [AW-1:0] m_addr;
    int            m_beats;
    int            m_starve;
    bit            fix_addr;
    bit            seq_data;

    // Per-cycle expectations for level outputs.
    bit            exp_mrv;
    logic [AW-1:0] exp_maddr;
    bit            exp_busy;
    bit            exp_mready;
    bit            exp_stray;

    grant_t gq[$];
    rsp_t   rq[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    task automatic flag(input string name, input int got, input int want);
        checks++;
        errors++;
        $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, got, want);
    endtask

    // One clock of stimulus; rates are percentages.
    task automatic step(input int p_dmd, input int p_pf, input int p_halt, input int p_rdy,
                        input int p_beat, input int p_stray, input bit rst);
        bit halt, dv, pv, rdy, bv;
        logic [MDW-1:0] data;
        bit win_pf;
        @(posedge clk);
        #1;
        halt = ($urandom_range(99) < p_halt);
        dv   = ($urandom_range(99) < p_dmd);
        pv   = ($urandom_range(99) < p_pf);
        rdy  = ($urandom_range(99) < p_rdy);
        bv   = (m_phase == PH_RECV) ? ($urandom_range(99) < p_beat)
                                    : ($urandom_range(99) < p_stray);
        data = seq_data ? MDW'(m_beats + 1) : MDW'({$urandom, $urandom});

        arst_n               = ~rst;
        bus.i_halt           = halt;
        bus.i_dmd_valid      = dv;
        bus.i_dmd_addr       = fix_addr ? 16'h1234 : AW'($urandom);
        bus.i_pf_valid       = pv;
        bus.i_pf_addr        = AW'($urandom);
        bus.i_mem_req_ready  = rdy;
        bus.i_mem_data_valid = bv;
        bus.i_mem_data       = data;

        exp_mrv    = !rst && (m_phase == PH_REQ);
        exp_maddr  = m_addr;
        exp_busy   = !rst && (m_phase != PH_IDLE);
        exp_mready = !rst && !halt && (m_phase == PH_RECV);
        exp_stray  = !rst && !halt && bv && (m_phase != PH_RECV);

        if (rst) begin
            m_phase  = PH_IDLE;
            m_beats  = 0;
            m_starve = 0;
            m_addr   = '0;
            m_pf     = 1'b0;
        end else if (!halt) begin
            if (m_phase == PH_IDLE) begin
                if (dv || pv) begin
                    win_pf = pv && (!dv || m_starve == SL);
                    gq.push_back('{cyc: cyc, pf: win_pf});
                    m_pf   = win_pf;
                    m_addr = win_pf ? bus.i_pf_addr : bus.i_dmd_addr;
                    if (win_pf) m_starve = 0;
                    else if (pv) m_starve = (m_starve < 3) ? m_starve + 1 : 3;
                    m_phase = PH_REQ;
                end
            end else if (m_phase == PH_REQ) begin
                if (rdy) begin
                    m_phase = PH_RECV;
                    m_beats = 0;
                end
            end else if (bv) begin
                rq.push_back('{cyc: cyc, pf: m_pf, data: data, last: (m_beats == NB - 1)});
                m_beats++;
                if (m_beats == NB) m_phase = PH_IDLE;
            end
        end
    endtask

    task automatic run_n(input int n, input int p_dmd, input int p_pf, input int p_halt,
                         input int p_rdy, input int p_beat, input int p_stray);
        for (int i = 0; i < n; i++) step(p_dmd, p_pf, p_halt, p_rdy, p_beat, p_stray, 1'b0);
    endtask

    // Monitor: pop expected transactions when the DUT presents them.
    always @(negedge clk) begin
        grant_t g;
        rsp_t   r;
        if (!arst_n) begin
            chk("reset_outputs",
                {bus.o_dmd_ready, bus.o_pf_ready, bus.o_mem_req_valid, bus.o_mem_ready,
                 bus.o_dmd_rsp_valid, bus.o_pf_rsp_valid, bus.o_rsp_last, bus.o_busy,
                 bus.o_stray_beat, |bus.o_mem_req_addr, |bus.o_rsp_data}, 0);
        end else begin
            while (gq.size() > 0 && gq[0].cyc < cyc) begin
                g = gq.pop_front();
                flag("grant_missing", 0, g.cyc);
            end
            if (bus.o_dmd_ready || bus.o_pf_ready) begin
                if (gq.size() == 0) flag("grant_extra", cyc, -1);
                else begin
                    g = gq.pop_front();
                    n_grants++;
                    chk("grant_cycle", cyc, g.cyc);
                    chk("grant_owner", {bus.o_pf_ready, bus.o_dmd_ready}, g.pf ? 2'b10 : 2'b01);
                end
            end
            while (rq.size() > 0 && rq[0].cyc < cyc) begin
                r = rq.pop_front();
                flag("rsp_missing", 0, r.cyc);
            end
            if (bus.o_dmd_rsp_valid || bus.o_pf_rsp_valid) begin
                if (rq.size() == 0) flag("rsp_extra", cyc, -1);
                else begin
                    r = rq.pop_front();
                    chk("rsp_cycle", cyc, r.cyc);
                    chk("rsp_owner", {bus.o_pf_rsp_valid, bus.o_dmd_rsp_valid}, r.pf ? 2'b10 : 2'b01);
                    chk("rsp_data", bus.o_rsp_data, r.data);
                    chk("rsp_last", bus.o_rsp_last, r.last);
                end
            end else begin
                chk("rsp_idle", {bus.o_rsp_last, bus.o_rsp_data}, 0);
            end
            chk("mem_req_valid", bus.o_mem_req_valid, exp_mrv);
            chk("mem_req_addr", bus.o_mem_req_addr, exp_mrv ? exp_maddr : '0);
            chk("busy", bus.o_busy, exp_busy);
            chk("mem_ready", bus.o_mem_ready, exp_mready);
            chk("stray_beat", bus.o_stray_beat, exp_stray);
        end
    end

    initial begin
        int guard;
        cyc = 0; checks = 0; errors = 0; n_grants = 0;
        m_phase = PH_IDLE; m_pf = 0; m_addr = '0; m_beats = 0; m_starve = 0;
        exp_mrv = 0; exp_maddr = '0; exp_busy = 0; exp_mready = 0; exp_stray = 0;
        fix_addr = 0; seq_data = 0;
        arst_n = 1'b0;
        bus.i_halt = 0; bus.i_dmd_valid = 0; bus.i_dmd_addr = '0;
        bus.i_pf_valid = 0; bus.i_pf_addr = '0; bus.i_mem_req_ready = 0;
        bus.i_mem_data_valid = 0; bus.i_mem_data = '0;

        // Reset with requests and beats present: outputs must stay quiet.
        for (int i = 0; i < 3; i++) step(100, 100, 0, 100, 100, 100, 1'b1);

        // Demand-only blocks at 0x1234 with beats 1..8.
        fix_addr = 1; seq_data = 1;
        run_n(60, 30, 0, 0, 40, 100, 0);
        fix_addr = 0; seq_data = 0;

        // Both requesters continuously valid: D,D,D,P pattern.
        run_n(200, 100, 100, 0, 100, 100, 0);

        // Halts sprinkled through all phases.
        run_n(300, 60, 60, 20, 60, 70, 0);

        // Stray beats outside block reception.
        run_n(150, 20, 20, 5, 50, 70, 30);

        // Memory stalls the request for 10 cycles.
        guard = 0;
        while (m_phase != PH_REQ && guard < 50) begin
            step(100, 0, 0, 0, 100, 0, 1'b0);
            guard++;
        end
        run_n(10, 50, 50, 0, 0, 0, 0);
        run_n(40, 0, 0, 0, 100, 100, 0);

        // Reset after the fifth beat of a block, then stray beats and a new demand.
        guard = 0;
        while (!(m_phase == PH_RECV && m_beats >= 5) && guard < 60) begin
            step(100, 0, 0, 100, 100, 0, 1'b0);
            guard++;
        end
        step(0, 0, 0, 0, 0, 0, 1'b1);
        run_n(3, 0, 0, 0, 0, 100, 100);
        run_n(40, 100, 0, 0, 100, 100, 0);

        // Random mix.
        for (int b = 0; b < 20; b++)
            run_n(100, $urandom_range(100), $urandom_range(100), $urandom_range(25),
                  $urandom_range(20, 100), $urandom_range(20, 100), $urandom_range(15));

        // Drain any block in flight.
        run_n(60, 0, 0, 0, 100, 100, 0);
        @(negedge clk);
        #1;
        chk("grant_queue_empty", gq.size(), 0);
        chk("rsp_queue_empty", rq.size(), 0);
        chk("grants_seen", (n_grants > 100), 1);
        chk("idle_at_end", bus.o_busy, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
